// File: rtl/spi_slave_frame_if.sv
// SPI pin and frame-bus bundle for spi_slave_frame.
// The slave modport is the DUT view; the master modport is the driver side.
interface spi_slave_frame_if #(
  parameter int CMD_W  = 2,
  parameter int DATA_W = 8
);
  localparam int FRAME_W = CMD_W + DATA_W;

  logic               ss_n;
  logic               sclk;
  logic               mosi;
  logic               miso;
  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_load;
  logic               busy;

  modport slave (
    input  ss_n, sclk, mosi, tx_data,
    output miso, rx_data, rx_valid, tx_load, busy
  );

  modport master (
    output ss_n, sclk, mosi, tx_data,
    input  miso, rx_data, rx_valid, tx_load, busy
  );
endinterface

// File: rtl/spi_slave_frame.sv
// SPI mode-0 slave front end: oversamples pins in clk, assembles {cmd,data} frames, serialises read data.
// Optional SPI_FRAME_ERR_EN adds a frame_err pulse on aborts and on sclk rises after a full frame.
module spi_slave_frame #(
  parameter int CMD_W       = 2,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  spi_slave_frame_if.slave bus
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic frame_err
`endif
);
  localparam int FRAME_W    = CMD_W + DATA_W;
  localparam int CNT_W      = $clog2(FRAME_W + 1);
  localparam int VLD_STAGES = 1;
  localparam logic [CNT_W-1:0] CNT_CMD   = CNT_W'(CMD_W);
  localparam logic [CNT_W-1:0] CNT_TX0   = CNT_W'(CMD_W + 1);
  localparam logic [CNT_W-1:0] CNT_FRAME = CNT_W'(FRAME_W);

  typedef enum logic [2:0] {IDLE, RX_CMD, RX_DATA, TX_DATA, DONE} state_e;

  state_e                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
  logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
  logic                   ss_n_dly_q, ss_n_dly_d;
  logic                   sclk_dly_q, sclk_dly_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  // The frame's last bit comes straight from mosi_s, so only FRAME_W-1 bits are held.
  logic [FRAME_W-2:0]     rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]     rx_data_q, rx_data_d;
  logic [DATA_W-1:0]      tx_shift_q, tx_shift_d;
  logic                   miso_q, miso_d;
  logic                   tx_load_q, tx_load_d;
  logic [VLD_STAGES:0]    vld_pipe_q, vld_pipe_d;

  logic ss_n_s, sclk_s, mosi_s;
  logic rise, fall, ss_fall, ss_rise, abort, frame_end;
  logic [FRAME_W-1:0] shift_in;
  logic [CNT_W-1:0]   cnt_inc;

  assign ss_n_s   = ss_sync_q[SYNC_STAGES-1];
  assign sclk_s   = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign rise     = sclk_s & ~sclk_dly_q;
  assign fall     = ~sclk_s & sclk_dly_q;
  assign ss_fall  = ~ss_n_s & ss_n_dly_q;
  assign ss_rise  = ss_n_s & ~ss_n_dly_q;
  assign abort    = ss_rise && (state_q inside {RX_CMD, RX_DATA, TX_DATA});
  assign shift_in = {rx_shift_q, mosi_s};
  assign cnt_inc  = bit_cnt_q + CNT_W'(1);

  always_comb begin
    ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], bus.ss_n};
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
    mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
    ss_n_dly_d  = ss_n_s;
    sclk_dly_d  = sclk_s;
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_data_d   = rx_data_q;
    tx_shift_d  = tx_shift_q;
    tx_load_d   = 1'b0;
    frame_end   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d   = RX_CMD;
          bit_cnt_d = '0;
        end
      end
      RX_CMD, RX_DATA, TX_DATA: begin
        // Deselect wins over a coincident sclk edge.
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end else begin
          if (rise) begin
            rx_shift_d = shift_in[FRAME_W-2:0];
            bit_cnt_d  = cnt_inc;
            if (state_q == RX_CMD && cnt_inc == CNT_CMD) begin
              if (&shift_in[CMD_W-1:0]) begin
                state_d    = TX_DATA;
                tx_shift_d = bus.tx_data;
                tx_load_d  = 1'b1;
              end else begin
                state_d = RX_DATA;
              end
            end
            if (state_q != RX_CMD && cnt_inc == CNT_FRAME) begin
              rx_data_d = shift_in;
              frame_end = 1'b1;
              state_d   = DONE;
            end
          end
          // The fall right after the command rise leaves the MSB on miso.
          if (state_q == TX_DATA && fall && bit_cnt_q >= CNT_TX0 && bit_cnt_q < CNT_FRAME)
            tx_shift_d = tx_shift_q << 1;
        end
      end
      DONE: begin
        if (ss_rise) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    miso_d     = (state_d == TX_DATA) ? tx_shift_d[DATA_W-1] : 1'b0;
    vld_pipe_d = {vld_pipe_q[VLD_STAGES-1:0], frame_end};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ss_sync_q   <= '1;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      ss_n_dly_q  <= 1'b1;
      sclk_dly_q  <= 1'b0;
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      rx_shift_q  <= '0;
      rx_data_q   <= '0;
      tx_shift_q  <= '0;
      miso_q      <= 1'b0;
      tx_load_q   <= 1'b0;
      vld_pipe_q  <= '0;
    end else begin
      ss_sync_q   <= ss_sync_d;
      sclk_sync_q <= sclk_sync_d;
      mosi_sync_q <= mosi_sync_d;
      ss_n_dly_q  <= ss_n_dly_d;
      sclk_dly_q  <= sclk_dly_d;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_data_q   <= rx_data_d;
      tx_shift_q  <= tx_shift_d;
      miso_q      <= miso_d;
      tx_load_q   <= tx_load_d;
      vld_pipe_q  <= vld_pipe_d;
    end
  end

  assign bus.miso     = miso_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = vld_pipe_q[VLD_STAGES];
  assign bus.tx_load  = tx_load_q;
  assign bus.busy     = ~ss_n_s;

`ifdef SPI_FRAME_ERR_EN
  logic frame_err_q, frame_err_d;
  logic done_rise;

  assign done_rise   = (state_q == DONE) && rise && !ss_rise;
  assign frame_err_d = (abort && bit_cnt_q != '0) || done_rise;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) frame_err_q <= 1'b0;
    else        frame_err_q <= frame_err_d;
  end

  assign frame_err = frame_err_q;
`endif
endmodule
